ddr_xfer_sequencer: RTL

//  Sequences one HDR-DDR transfer over the shared SCL/bit/frame datapath: scl_generation, bits_counter, frame_counter.

---
 rtl/ddr_seq_pkg.sv | 21 ++
 rtl/ddr_seq_watchdog.sv | 39 +++
 rtl/ddr_xfer_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ddr_seq_pkg.sv
// Shared types and widths for the HDR-DDR transfer sequencer.
package ddr_seq_pkg;

  localparam int TIMER_W = 12;
  localparam int FRAME_W = 8;
  localparam int EDGE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FRAMES,
    ST_FINISH,
    ST_ERROR
  } seq_state_e;

  // The frame index sticks at its maximum instead of wrapping.
  function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ddr_seq_watchdog.sv
// Per-frame watchdog: counts enabled, unfrozen clocks; flags expiry at the limit.
// Clear wins over counting; the count never wraps.
module ddr_seq_watchdog
  import ddr_seq_pkg::*;
#(
  parameter int P_TIMEOUT = 4095
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_freeze,
  output logic o_expire
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(P_TIMEOUT);

  logic [TIMER_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (i_clr) begin
      timer_d = '0;
    end else if (i_en && !i_freeze && (timer_q != LIMIT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign o_expire = i_en && (timer_q == LIMIT);

endmodule

// File: rtl/ddr_xfer_sequencer.sv
// Sequences one HDR-DDR transfer: SETUP edges, frame loop, then a done or err pulse.
// Every output is a flop loaded from the next-state decode; host stall reaches SCL 1 clock later.
module ddr_xfer_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int P_SETUP_EDGES = 4,
  parameter int P_TIMEOUT     = 4095,
  parameter int P_MAX_FRAMES  = 255
) (
  input  logic               i_sys_clk,
  input  logic               i_rst,
  input  logic               i_seq_start,
  input  logic               i_seq_abort,
  input  logic               i_host_stall,
  input  logic               i_scl_pos_edge,
  input  logic               i_bitcnt_toggle,
  input  logic               i_cccnt_last_frame,
  output logic               o_scl_gen_pp_od,
  output logic               o_scl_gen_stall,
  output logic               o_sdr_ctrl_scl_idle,
  output logic               o_bitcnt_en,
  output logic               o_fcnt_en,
  output logic               o_bitcnt_err_rst,
  output logic [FRAME_W-1:0] o_frame_idx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [EDGE_W-1:0]  LAST_EDGE = EDGE_W'(P_SETUP_EDGES - 1);
  localparam logic [FRAME_W-1:0] MAX_IDX   = FRAME_W'(P_MAX_FRAMES);

  seq_state_e         state_q, state_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic [FRAME_W-1:0] idx_inc;
  logic pp_od_q, pp_od_d, stall_q, stall_d, scl_idle_q, scl_idle_d;
  logic bitcnt_en_q, bitcnt_en_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d;
  logic expire;
  logic active_d;

  assign idx_inc = sat_inc(frame_idx_q);

  // The timer only runs inside the frame loop and restarts at every frame boundary.
  ddr_seq_watchdog #(.P_TIMEOUT(P_TIMEOUT)) u_watchdog (
    .i_clk    (i_sys_clk),
    .i_rst    (i_rst),
    .i_en     (state_q == ST_FRAMES),
    .i_clr    ((state_q != ST_FRAMES) || i_bitcnt_toggle),
    .i_freeze (stall_q),
    .o_expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    frame_idx_d = frame_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_seq_start) begin
          state_d     = ST_SETUP;
          edge_cnt_d  = '0;
          frame_idx_d = '0;
        end
      end
      ST_SETUP: begin
        if (i_seq_abort) begin
          state_d = ST_ERROR;
        end else if (i_scl_pos_edge) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (edge_cnt_q == LAST_EDGE) state_d = ST_FRAMES;
        end
      end
      ST_FRAMES: begin
        // Abort pre-empts a coincident toggle, so the index is left untouched.
        if (i_seq_abort) begin
          state_d = ST_ERROR;
        end else if (i_bitcnt_toggle) begin
          frame_idx_d = idx_inc;
          if (i_cccnt_last_frame)      state_d = ST_FINISH;
          else if (idx_inc == MAX_IDX) state_d = ST_ERROR;
        end else if (expire) begin
          state_d = ST_ERROR;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    active_d    = (state_d == ST_SETUP) || (state_d == ST_FRAMES);
    pp_od_d     = active_d;
    scl_idle_d  = !active_d;
    stall_d     = active_d && i_host_stall;
    bitcnt_en_d = (state_d == ST_FRAMES);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FINISH);
    err_d       = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      edge_cnt_q  <= '0;
      frame_idx_q <= '0;
      pp_od_q     <= 1'b0;
      stall_q     <= 1'b0;
      scl_idle_q  <= 1'b1;
      bitcnt_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      frame_idx_q <= frame_idx_d;
      pp_od_q     <= pp_od_d;
      stall_q     <= stall_d;
      scl_idle_q  <= scl_idle_d;
      bitcnt_en_q <= bitcnt_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_scl_gen_pp_od     = pp_od_q;
  assign o_scl_gen_stall     = stall_q;
  assign o_sdr_ctrl_scl_idle = scl_idle_q;
  assign o_bitcnt_en         = bitcnt_en_q;
  assign o_fcnt_en           = bitcnt_en_q;
  assign o_bitcnt_err_rst    = err_q;
  assign o_frame_idx         = frame_idx_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_err               = err_q;

endmodule
